wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, range 1..15: consecutive cycles a pending multi-cycle result may lose arbitration before the pipeline is stalled.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_pipe_we  input  1  pipeline (MEM stage) requests a register-file write.
REQ-005 i_pipe_rw  input  5  pipeline destination register.
REQ-006 i_pipe_data  input  32  pipeline write data.
REQ-007 i_mc_valid  input  1  multi-cycle unit (mult/div) offers a result.
REQ-008 i_mc_rw  input  5  multi-cycle destination register.
REQ-009 i_mc_data  input  32  multi-cycle result data.
REQ-010 o_mc_ready  output  1  result buffer can accept; a transfer occurs when i_mc_valid && o_mc_ready.
REQ-011 o_stall  output  1  pipeline must hold MEM-stage inputs stable this cycle.
REQ-012 o_rf_we  output  1  registered register-file write enable.
REQ-013 o_rf_rw  output  5  registered register-file write address.
REQ-014 o_rf_data  output  32  registered register-file write data.
REQ-015 o_grant_mc  output  1  registered; 1 = current o_rf_* write comes from the result buffer.
REQ-016 o_busy_mask  output  32  bit k = 1 while any buffered entry targets register k.

Function
REQ-017 The result buffer SHALL be a 2-entry FIFO; o_mc_ready = (count < 2), derived from registered state only.
REQ-018 An accepted entry with i_mc_rw = 0 SHALL be discarded: count unchanged, no write, no busy bit.
REQ-019 A pipeline request with i_pipe_rw = 0 SHALL be treated as i_pipe_we = 0.
REQ-020 Arbitration per cycle: if the FIFO is non-empty and starve_cnt == STARVE_LIMIT, the FIFO head wins and o_stall = i_pipe_we; else if i_pipe_we, the pipeline wins; else if the FIFO is non-empty, the FIFO head wins; else there is no grant.
REQ-021 o_stall SHALL be combinational and asserted only in the starvation case of REQ-020.
REQ-022 The winner SHALL appear on o_rf_* at the next rising edge (one-cycle latency); with no grant, o_rf_we = 0 and o_rf_rw/o_rf_data hold previous values.
REQ-023 A buffered result SHALL be written no earlier than the second edge after its acceptance: accept at edge N, eligible in cycle N+1, on o_rf_* at edge N+2.
REQ-024 A FIFO head win SHALL pop the entry at the same edge that loads o_rf_*.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-026 starve_cnt (4 bits) SHALL increment, saturating at STARVE_LIMIT, when the FIFO is non-empty and the head loses; it SHALL clear when the head wins or the FIFO is empty.
REQ-027 o_busy_mask SHALL be the OR of one-hot decodes of the valid entries' rw, computed from registered FIFO state; a popped entry's bit clears at the pop edge unless the other entry has the same rw.
REQ-028 Two buffered entries to the same register SHALL both be written, in acceptance order; WAW between buffer and pipeline is prevented upstream using o_busy_mask.

Reset
REQ-029 While i_rst_n = 0 at a rising edge: FIFO empty, starve_cnt = 0, o_rf_we = 0, o_rf_rw = 0, o_rf_data = 0, o_grant_mc = 0; hence o_mc_ready = 1, o_stall = 0, o_busy_mask = 0.
REQ-030 Reset asserted mid-operation SHALL drop all buffered entries without writing them; i_mc_valid during reset is ignored.

Verification
REQ-031 Pipe only: i_pipe_we=1, rw=5, data=0xDEADBEEF at edge N -> o_rf_we=1, rw=5, data=0xDEADBEEF, o_grant_mc=0 after edge N+1.
REQ-032 Idle pipe: mc rw=9, data=0x12 accepted at edge N -> o_busy_mask=0x200 after N; after N+2, o_rf_we=1, rw=9, o_grant_mc=1; o_busy_mask=0.
REQ-033 Full: two mc entries accepted while pipe writes continuously -> o_mc_ready=0; third i_mc_valid is held until a pop.
REQ-034 Starvation, STARVE_LIMIT=4: entry buffered, pipe writes every cycle -> after 4 lost cycles o_stall=1 for one cycle, head written with o_grant_mc=1, then held pipe write follows.
REQ-035 Zero register: mc rw=0 accepted -> no busy bit, no write; pipe rw=0 -> o_rf_we=0.
REQ-036 Reset with 2 entries buffered -> next cycle o_mc_ready=1, o_busy_mask=0, and no writes occur.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the MEM-stage pipeline writes compete with a 2-entry mult/div result buffer.
// Winner appears on o_rf_* one edge later; buffered results wait at least one cycle, and starvation stalls the pipe.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pipe_we,
  input  logic [4:0]  i_pipe_rw,
  input  logic [31:0] i_pipe_data,
  input  logic        i_mc_valid,
  input  logic [4:0]  i_mc_rw,
  input  logic [31:0] i_mc_data,
  output logic        o_mc_ready,
  output logic        o_stall,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_rw,
  output logic [31:0] o_rf_data,
  output logic        o_grant_mc,
  output logic [31:0] o_busy_mask
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  // Shift-style FIFO: slot 0 is always the head.
  logic [1:0]  r_cnt;
  logic [4:0]  r_ent_rw   [2];
  logic [31:0] r_ent_data [2];
  logic [1:0]  r_ent_elig;
  logic [3:0]  r_starve_cnt;

  logic        w_pipe_we;
  logic        w_push;
  logic        w_head_vld;
  logic        w_starve;
  logic        w_grant_mc;
  logic        w_grant_pipe;
  logic [1:0]  w_nxt_cnt;
  logic [4:0]  w_nxt_rw   [2];
  logic [31:0] w_nxt_data [2];
  logic [1:0]  w_nxt_elig;

  assign w_pipe_we    = i_pipe_we && (i_pipe_rw != 5'd0);
  assign o_mc_ready   = (r_cnt != 2'd2);
  // Zero-register results are accepted but never enter the buffer.
  assign w_push       = i_mc_valid && o_mc_ready && (i_mc_rw != 5'd0);
  assign w_head_vld   = (r_cnt != 2'd0) && r_ent_elig[0];
  assign w_starve     = w_head_vld && (r_starve_cnt == LP_LIMIT);
  assign w_grant_mc   = w_head_vld && (w_starve || !w_pipe_we);
  assign w_grant_pipe = w_pipe_we && !w_starve;
  assign o_stall      = w_starve && w_pipe_we;

  always_comb begin
    o_busy_mask = '0;
    if (r_cnt != 2'd0) o_busy_mask[r_ent_rw[0]] = 1'b1;
    if (r_cnt == 2'd2) o_busy_mask[r_ent_rw[1]] = 1'b1;
  end

  // Surviving entries become eligible; a freshly pushed one waits a cycle.
  always_comb begin
    w_nxt_cnt     = r_cnt;
    w_nxt_rw[0]   = r_ent_rw[0];
    w_nxt_rw[1]   = r_ent_rw[1];
    w_nxt_data[0] = r_ent_data[0];
    w_nxt_data[1] = r_ent_data[1];
    w_nxt_elig    = 2'b11;
    if (w_grant_mc) begin
      w_nxt_rw[0]   = r_ent_rw[1];
      w_nxt_data[0] = r_ent_data[1];
      w_nxt_cnt     = r_cnt - 2'd1;
    end
    if (w_push) begin
      w_nxt_rw[w_nxt_cnt[0]]   = i_mc_rw;
      w_nxt_data[w_nxt_cnt[0]] = i_mc_data;
      w_nxt_elig[w_nxt_cnt[0]] = 1'b0;
      w_nxt_cnt                = w_nxt_cnt + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt         <= 2'd0;
      r_ent_rw[0]   <= 5'd0;
      r_ent_rw[1]   <= 5'd0;
      r_ent_data[0] <= 32'd0;
      r_ent_data[1] <= 32'd0;
      r_ent_elig    <= 2'b00;
      r_starve_cnt  <= 4'd0;
      o_rf_we       <= 1'b0;
      o_rf_rw       <= 5'd0;
      o_rf_data     <= 32'd0;
      o_grant_mc    <= 1'b0;
    end else begin
      r_cnt         <= w_nxt_cnt;
      r_ent_rw[0]   <= w_nxt_rw[0];
      r_ent_rw[1]   <= w_nxt_rw[1];
      r_ent_data[0] <= w_nxt_data[0];
      r_ent_data[1] <= w_nxt_data[1];
      r_ent_elig    <= w_nxt_elig;

      if (!w_head_vld || w_grant_mc) begin
        r_starve_cnt <= 4'd0;
      end else if (r_starve_cnt != LP_LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end

      if (w_grant_mc) begin
        o_rf_we    <= 1'b1;
        o_rf_rw    <= r_ent_rw[0];
        o_rf_data  <= r_ent_data[0];
        o_grant_mc <= 1'b1;
      end else if (w_grant_pipe) begin
        o_rf_we    <= 1'b1;
        o_rf_rw    <= i_pipe_rw;
        o_rf_data  <= i_pipe_data;
        o_grant_mc <= 1'b0;
      end else begin
        o_rf_we    <= 1'b0;
        o_grant_mc <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, pipe/buffer arbitration, full buffer, starvation, zero register, WAW order, mid-run reset.
module tb_wb_port_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_pipe_we;
  logic [4:0]  i_pipe_rw;
  logic [31:0] i_pipe_data;
  logic        i_mc_valid;
  logic [4:0]  i_mc_rw;
  logic [31:0] i_mc_data;
  logic        o_mc_ready;
  logic        o_stall;
  logic        o_rf_we;
  logic [4:0]  o_rf_rw;
  logic [31:0] o_rf_data;
  logic        o_grant_mc;
  logic [31:0] o_busy_mask;

  int n_cmp = 0;
  int n_err = 0;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_pipe_we   (i_pipe_we),
    .i_pipe_rw   (i_pipe_rw),
    .i_pipe_data (i_pipe_data),
    .i_mc_valid  (i_mc_valid),
    .i_mc_rw     (i_mc_rw),
    .i_mc_data   (i_mc_data),
    .o_mc_ready  (o_mc_ready),
    .o_stall     (o_stall),
    .o_rf_we     (o_rf_we),
    .o_rf_rw     (o_rf_rw),
    .o_rf_data   (o_rf_data),
    .o_grant_mc  (o_grant_mc),
    .o_busy_mask (o_busy_mask)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [4:0] rw, input logic [31:0] d);
    i_pipe_we = we; i_pipe_rw = rw; i_pipe_data = d;
  endtask

  task automatic mc(input logic v, input logic [4:0] rw, input logic [31:0] d);
    i_mc_valid = v; i_mc_rw = rw; i_mc_data = d;
  endtask

  initial begin
    i_rst_n = 1'b0;
    pipe(1'b0, 5'd0, 32'd0);
    mc(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    check("rst_we",    32'(o_rf_we), 32'd0);
    check("rst_rw",    32'(o_rf_rw), 32'd0);
    check("rst_data",  o_rf_data, 32'd0);
    check("rst_grant", 32'(o_grant_mc), 32'd0);
    check("rst_ready", 32'(o_mc_ready), 32'd1);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_busy",  o_busy_mask, 32'd0);
    i_rst_n = 1'b1;
    tick();

    // Pipe-only write, then idle holds address/data
    pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check("pipe_we",    32'(o_rf_we), 32'd1);
    check("pipe_rw",    32'(o_rf_rw), 32'd5);
    check("pipe_data",  o_rf_data, 32'hDEADBEEF);
    check("pipe_grant", 32'(o_grant_mc), 32'd0);
    pipe(1'b0, 5'd0, 32'd0);
    tick();
    check("idle_we",   32'(o_rf_we), 32'd0);
    check("idle_rw",   32'(o_rf_rw), 32'd5);
    check("idle_data", o_rf_data, 32'hDEADBEEF);

    // Single buffered result with idle pipe: written two edges after acceptance
    mc(1'b1, 5'd9, 32'h12);
    check("mc1_ready", 32'(o_mc_ready), 32'd1);
    tick();
    mc(1'b0, 5'd0, 32'd0);
    check("mc1_busy_n",  o_busy_mask, 32'h200);
    check("mc1_we_n",    32'(o_rf_we), 32'd0);
    tick();
    check("mc1_we_n1",   32'(o_rf_we), 32'd0);
    check("mc1_busy_n1", o_busy_mask, 32'h200);
    tick();
    check("mc1_we",    32'(o_rf_we), 32'd1);
    check("mc1_rw",    32'(o_rf_rw), 32'd9);
    check("mc1_data",  o_rf_data, 32'h12);
    check("mc1_grant", 32'(o_grant_mc), 32'd1);
    check("mc1_busy",  o_busy_mask, 32'd0);
    tick();
    check("mc1_after_we", 32'(o_rf_we), 32'd0);

    // Full buffer under continuous pipe traffic, then starvation stall
    pipe(1'b1, 5'd3, 32'h33);
    mc(1'b1, 5'd10, 32'hA1);
    tick();
    check("full_pipe_rw",    32'(o_rf_rw), 32'd3);
    check("full_pipe_grant", 32'(o_grant_mc), 32'd0);
    check("full_ready1",     32'(o_mc_ready), 32'd1);
    mc(1'b1, 5'd11, 32'hB1);
    tick();
    check("full_ready0", 32'(o_mc_ready), 32'd0);
    check("full_busy",   o_busy_mask, 32'h0C00);
    mc(1'b1, 5'd12, 32'hC1);
    for (int i = 0; i < 4; i++) begin
      check("starve_no_stall", 32'(o_stall), 32'd0);
      check("starve_held",     32'(o_mc_ready), 32'd0);
      tick();
      check("starve_pipe_rw", 32'(o_rf_rw), 32'd3);
    end
    check("starve_stall", 32'(o_stall), 32'd1);
    tick();
    check("starve_grant",  32'(o_grant_mc), 32'd1);
    check("starve_rw",     32'(o_rf_rw), 32'd10);
    check("starve_data",   o_rf_data, 32'hA1);
    check("starve_clear",  32'(o_stall), 32'd0);
    check("starve_ready",  32'(o_mc_ready), 32'd1);
    check("starve_busy",   o_busy_mask, 32'h0800);
    tick();
    check("held_pipe_we",    32'(o_rf_we), 32'd1);
    check("held_pipe_rw",    32'(o_rf_rw), 32'd3);
    check("held_pipe_grant", 32'(o_grant_mc), 32'd0);
    check("third_busy",      o_busy_mask, 32'h1800);
    mc(1'b0, 5'd0, 32'd0);
    pipe(1'b0, 5'd0, 32'd0);
    tick();
    check("drain_b_rw",    32'(o_rf_rw), 32'd11);
    check("drain_b_data",  o_rf_data, 32'hB1);
    check("drain_b_grant", 32'(o_grant_mc), 32'd1);
    tick();
    check("drain_c_rw",   32'(o_rf_rw), 32'd12);
    check("drain_c_data", o_rf_data, 32'hC1);
    check("drain_busy",   o_busy_mask, 32'd0);
    tick();
    check("drain_idle", 32'(o_rf_we), 32'd0);

    // Zero register on both sides
    mc(1'b1, 5'd0, 32'h55);
    check("zero_ready", 32'(o_mc_ready), 32'd1);
    tick();
    mc(1'b0, 5'd0, 32'd0);
    check("zero_busy", o_busy_mask, 32'd0);
    tick();
    check("zero_mc_we0", 32'(o_rf_we), 32'd0);
    tick();
    check("zero_mc_we1", 32'(o_rf_we), 32'd0);
    pipe(1'b1, 5'd0, 32'h77);
    tick();
    check("zero_pipe_we", 32'(o_rf_we), 32'd0);
    pipe(1'b0, 5'd0, 32'd0);

    // Two entries to the same register drain in acceptance order
    mc(1'b1, 5'd7, 32'h71);
    tick();
    mc(1'b1, 5'd7, 32'h72);
    tick();
    mc(1'b0, 5'd0, 32'd0);
    check("waw_busy2", o_busy_mask, 32'h80);
    tick();
    check("waw_first",  o_rf_data, 32'h71);
    check("waw_busy1",  o_busy_mask, 32'h80);
    tick();
    check("waw_second", o_rf_data, 32'h72);
    check("waw_rw",     32'(o_rf_rw), 32'd7);
    check("waw_busy0",  o_busy_mask, 32'd0);
    tick();

    // Reset with two entries buffered drops them
    pipe(1'b1, 5'd3, 32'h33);
    mc(1'b1, 5'd20, 32'h201);
    tick();
    mc(1'b1, 5'd21, 32'h211);
    tick();
    check("prerst_ready", 32'(o_mc_ready), 32'd0);
    i_rst_n = 1'b0;
    pipe(1'b0, 5'd0, 32'd0);
    mc(1'b1, 5'd22, 32'h221);
    tick();
    check("rst2_ready", 32'(o_mc_ready), 32'd1);
    check("rst2_busy",  o_busy_mask, 32'd0);
    check("rst2_we",    32'(o_rf_we), 32'd0);
    i_rst_n = 1'b1;
    mc(1'b0, 5'd0, 32'd0);
    tick();
    check("rst2_we_a", 32'(o_rf_we), 32'd0);
    tick();
    check("rst2_we_b", 32'(o_rf_we), 32'd0);
    tick();
    check("rst2_we_c",  32'(o_rf_we), 32'd0);
    check("rst2_busy2", o_busy_mask, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
